exe_mdu_pipe: RTL and testbench
===============================

# exe_mdu_pipe

Parametrised multiply/divide unit with integrated HI/LO registers, the next generation of the EXE-stage MULTDIV/HILO pair. Supports configurable datapath width, a pipelined multiplier of selectable depth, and a divider retiring a selectable number of quotient bits per cycle. Also supports MADD/MADDU/MSUB/MSUBU accumulate and the GPR-writing MUL. Sits in TOP_EXE, fed by the bypassed EXE_BusA/EXE_BusB. Stalls the pipeline while busy and commits HI/LO only when the EXE stage advances.

## Interface
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- MUL_STAGES, 2: multiplier latency in cycles, legal values 1..4.
- DIV_BITS, 1: quotient bits retired per divide cycle; legal values 1, 2, 4, must divide WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- flush  in  1  EXE flush (exception/redirect); aborts any operation.
- start  in  1  EXE instruction is an MDU op; sampled only in IDLE.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MUL; others are no-op.
- a, b  in  WIDTH  operands; a is also MTHI/MTLO data.
- ack  in  1  EXE stage advancing (EXE_Wr).
- dis_wr  in  1  commit suppress (EXE_DisWr); blocks HI/LO writes.
- hi_we, lo_we  in  1  MTHI/MTLO write requests.
- stall  out  1  hold pipeline; reset 0.
- done  out  1  result valid; reset 0.
- mul_lo  out  WIDTH  low half of the product for MUL; reset 0.
- hi, lo  out  WIDTH  architectural HI/LO; reset 0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE + start + op MULT..MSUBU/MUL -> MUL. IDLE + start + op DIV/DIVU -> DIV.
  - Operands are latched at the transition.
  - Signed ops use two's complement; unsigned ops zero-extend.
- MUL: computes the 2*WIDTH product through MUL_STAGES register stages, then -> DONE.
  - MADD*: result = {hi,lo} + product. MSUB*: result = {hi,lo} - product. Both are modulo 2^(2*WIDTH), using the HI/LO values latched at start.
- DIV: restoring divide on absolute values, DIV_BITS quotient bits per cycle, WIDTH/DIV_BITS cycles, then -> DONE.
  - Signed fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = a. No exception.
  - Signed overflow: min_int / -1 gives quotient = min_int, remainder = 0.
- DONE: done=1 and the result is held. Start is ignored.
  - ack=1: -> IDLE. HI/LO take the result unless dis_wr=1 or op is MUL; MUL only drives mul_lo.
  - ack=0: remain in DONE.
- flush in any state: -> IDLE next edge. No HI/LO write; done and stall drop next cycle.
- MTHI/MTLO: in IDLE with start=0, hi_we/lo_we write `a` to HI/LO at the edge unless dis_wr=1.
  - A simultaneous flush suppresses the write.
  - hi_we/lo_we are ignored outside IDLE.
- Simultaneous MDU commit in DONE and hi_we/lo_we cannot occur (same EXE slot); if they do, the MDU result wins.
- Unused op codes with start: stay in IDLE, no stall.

## Timing
- stall is combinational.
  - Asserted for start & accepted-op in IDLE (cycle 0).
  - Asserted in every MUL/DIV cycle.
  - Deasserted in DONE.
- Multiply: DONE is entered MUL_STAGES cycles after the accept edge, so done rises in cycle MUL_STAGES+1 counting the start cycle as 0.
- Divide: done rises in cycle WIDTH/DIV_BITS+1 (the final signed fixup is folded into the last iteration).
- HI/LO update on the edge ending the DONE&ack cycle; they are visible the following cycle.
- mul_lo is stable from done=1 until leaving DONE.
- resetn=0: all registers and outputs cleared at the next edge, including mid-operation. Reset has priority over flush.
- Back-to-back ops: a new start is accepted no earlier than the cycle after DONE&ack.
- MADD reading HI/LO directly after a prior commit sees the committed values; no internal bypass is needed because of the IDLE gap.

## Test plan
- WIDTH=32, MUL_STAGES=2: MULT a=0xFFFFFFFE (-2), b=3 -> stall cycles 0-2, done cycle 3; after ack hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=-7, b=2, DIV_BITS=1 -> done in cycle 33; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with DIV_BITS=4 -> done in cycle 9.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. Signed DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0. Then MSUB a=1, b=1 -> hi=0, lo=0xFFFFFFFF.
- Flush in the 10th DIV cycle -> IDLE next cycle, stall=0, hi/lo unchanged. Repeat with dis_wr=1 in DONE -> hi/lo unchanged, return to IDLE.
- Hold ack=0 for 3 cycles in DONE -> done stays 1, stall 0, no write; MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle; resetn=0 mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/exe_mdu_pipe.sv
// exe_mdu_pipe: EXE-stage multiply/divide unit with architectural HI/LO.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   resetn         synchronous active-low reset
//   flush          EXE flush, aborts any operation without touching HI/LO
//   start          EXE instruction is an MDU op (looked at only in IDLE)
//   op[3:0]        0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU 8 MUL
//   a, b           operands; a also carries MTHI/MTLO data
//   ack            EXE stage advancing; commits a finished result
//   dis_wr         suppresses every HI/LO write
//   hi_we, lo_we   MTHI / MTLO requests (IDLE only)
//   stall          hold the pipeline (combinational)
//   done           result valid
//   mul_lo         low half of the product for MUL, valid while done
//   hi, lo         architectural HI/LO
module exe_mdu_pipe #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    input  logic             dis_wr,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2      = 2 * WIDTH;
    localparam int DIV_CYC = WIDTH / DIV_BITS;
    localparam int CNT_W   = $clog2((DIV_CYC > MUL_STAGES) ? DIV_CYC : MUL_STAGES) + 1;

    localparam logic [3:0] OP_DIV  = 4'd2;
    localparam logic [3:0] OP_DIVU = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       op_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [W2-1:0]    acc_reg;
    logic [W2-1:0]    pipe_reg [MUL_STAGES];
    logic [WIDTH-1:0] q_reg, r_reg, dvs_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    // Input decode
    logic op_is_div, op_is_mul, accept;
    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign op_is_mul = (op <= OP_MUL) && !op_is_div;
    assign accept    = (state_reg == S_IDLE) && start && (op_is_mul || op_is_div);

    // Even op codes are the signed variants.
    logic             sgn_in;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign sgn_in = ~op[0];
    assign a_abs  = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign b_abs  = (sgn_in && b[WIDTH-1]) ? -b : b;

    logic mul_last, div_last;
    assign mul_last = (cnt_reg == CNT_W'(MUL_STAGES - 1));
    assign div_last = (cnt_reg == CNT_W'(DIV_CYC - 1));

    // FSM
    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = op_is_div ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (mul_last) state_next = S_DONE;
            end
            S_DIV: begin
                stall = 1'b1;
                if (div_last) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // Multiplier: full-width extension makes the truncated product correct
    // for both signed and unsigned operands.
    logic [W2-1:0] a_ext, b_ext, product;
    assign a_ext   = sgn_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    assign b_ext   = sgn_reg ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    assign product = a_ext * b_ext;

    // Accumulate is folded into the last multiplier stage.
    function automatic logic [W2-1:0] mac(input logic [3:0] o, input logic [W2-1:0] acc,
                                          input logic [W2-1:0] p);
        case (o)
            4'd4, 4'd5: mac = acc + p;
            4'd6, 4'd7: mac = acc - p;
            default:    mac = p;
        endcase
    endfunction

    // Restoring divider: DIV_BITS quotient bits per cycle on magnitudes.
    logic [WIDTH-1:0] q_step, r_step, q_fin, r_fin;
    logic [WIDTH:0]   trial, diff;
    logic             neg_q, neg_r, div_zero;
    assign neg_q    = sgn_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
    assign neg_r    = sgn_reg && a_reg[WIDTH-1];
    assign div_zero = (b_reg == '0);

    always_comb begin
        q_step = q_reg;
        r_step = r_reg;
        trial  = '0;
        diff   = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            trial  = {r_step, q_step[WIDTH-1]};
            q_step = {q_step[WIDTH-2:0], 1'b0};
            diff   = trial - {1'b0, dvs_reg};
            if (!diff[WIDTH]) begin
                r_step    = diff[WIDTH-1:0];
                q_step[0] = 1'b1;
            end else begin
                r_step = trial[WIDTH-1:0];
            end
        end
        // Sign fixup / divide-by-zero result applied on the final iteration.
        q_fin = div_zero ? '1    : (neg_q ? -q_step : q_step);
        r_fin = div_zero ? a_reg : (neg_r ? -r_step : r_step);
    end

    logic          res_is_div;
    logic [W2-1:0] res;
    assign res_is_div = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    assign res        = res_is_div ? {r_reg, q_reg} : pipe_reg[MUL_STAGES-1];

    // Datapath and HI/LO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg <= '0;
            op_reg  <= '0;
            sgn_reg <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dvs_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            for (int i = 0; i < MUL_STAGES; i++) pipe_reg[i] <= '0;
        end else begin
            if (accept) begin
                cnt_reg <= '0;
                op_reg  <= op;
                sgn_reg <= sgn_in;
                a_reg   <= a;
                b_reg   <= b;
                acc_reg <= {hi_reg, lo_reg};
                q_reg   <= a_abs;
                r_reg   <= '0;
                dvs_reg <= b_abs;
            end

            // Pipeline advances only while in MUL so the last stage holds in DONE.
            if (state_reg == S_MUL) begin
                cnt_reg     <= cnt_reg + CNT_W'(1);
                pipe_reg[0] <= (MUL_STAGES == 1) ? mac(op_reg, acc_reg, product) : product;
                for (int i = 1; i < MUL_STAGES; i++) begin
                    pipe_reg[i] <= (i == MUL_STAGES - 1) ? mac(op_reg, acc_reg, pipe_reg[i-1])
                                                         : pipe_reg[i-1];
                end
            end

            if (state_reg == S_DIV) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                q_reg   <= div_last ? q_fin : q_step;
                r_reg   <= div_last ? r_fin : r_step;
            end

            if (state_reg == S_DONE) begin
                if (ack && !flush && !dis_wr && (op_reg != OP_MUL)) begin
                    hi_reg <= res[W2-1:WIDTH];
                    lo_reg <= res[WIDTH-1:0];
                end
            end else if (state_reg == S_IDLE && !start && !flush && !dis_wr) begin
                if (hi_we) hi_reg <= a;
                if (lo_we) lo_reg <= a;
            end
        end
    end

    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign mul_lo = (state_reg == S_DONE && op_reg == OP_MUL) ? res[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_exe_mdu_pipe.sv
// tb_exe_mdu_pipe: directed plus randomized checks of exe_mdu_pipe against a
// plain-arithmetic model of HI/LO and the expected result latencies.
module tb_exe_mdu_pipe;

    localparam int W  = 32;
    localparam int MS = 2;
    localparam int DB = 1;

    logic          clk = 1'b0;
    logic          resetn, flush, start, ack, dis_wr, hi_we, lo_we;
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic          stall, done;
    logic [W-1:0]  mul_lo, hi, lo;

    exe_mdu_pipe #(.WIDTH(W), .MUL_STAGES(MS), .DIV_BITS(DB)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .start(start), .op(op),
        .a(a), .b(b), .ack(ack), .dis_wr(dis_wr), .hi_we(hi_we), .lo_we(lo_we),
        .stall(stall), .done(done), .mul_lo(mul_lo), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] hi_m  = '0;
    logic [W-1:0] lo_m  = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {HI,LO} an operation should produce, from the instruction semantics.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] hl);
        longint       sx, sy, q, r;
        logic [63:0]  ps, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ps = sx * sy;
        pu = {32'b0, x} * {32'b0, y};
        case (o)
            4'd0, 4'd8: return ps;
            4'd1:       return pu;
            4'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            4'd4:    return hl + ps;
            4'd5:    return hl + pu;
            4'd6:    return hl - ps;
            4'd7:    return hl - pu;
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // One full MDU transaction: start, wait for done, hold, ack, check commit.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input logic dw);
        logic [63:0] exp;
        int          cyc, lat;
        logic        got, busy_ok;
        exp = ref_result(o, x, y, {hi_m, lo_m});
        lat = (o == 4'd2 || o == 4'd3) ? W / DB + 1 : MS + 1;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; ack = 1'b0; dis_wr = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("stall_c0", 64'(stall), 64'(1));
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 200) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            hi_we = 1'($urandom_range(0, 1));
            lo_we = 1'($urandom_range(0, 1));
            cyc++;
            @(negedge clk);
            if (done) got = 1'b1;
            else if (!stall) busy_ok = 1'b0;
        end
        check_val("done_seen", 64'(got), 64'(1));
        check_val("latency", 64'(cyc), 64'(lat));
        check_val("busy_stall", 64'(busy_ok), 64'(1));
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin @(posedge clk); #1; end
            if (h < hold) begin
                start = 1'($urandom_range(0, 1));
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; ack = 1'b0;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; ack = 1'b1; dis_wr = dw;
            end
            #1;
            check_val("done_hold", 64'(done), 64'(1));
            check_val("stall_done", 64'(stall), 64'(0));
            if (o == 4'd8) check_val("mul_lo", 64'(mul_lo), 64'(exp[31:0]));
            if (h == hold) begin
                check_val("hi_pre", 64'(hi), 64'(hi_m));
                check_val("lo_pre", 64'(lo), 64'(lo_m));
            end
        end
        @(posedge clk); #1;
        ack = 1'b0; dis_wr = 1'b0;
        if (!dw && o != 4'd8) {hi_m, lo_m} = exp;
        @(negedge clk);
        $display("op=%0d a=%h b=%h hold=%0d dis_wr=%0b -> hi=%h lo=%h", o, x, y, hold, dw, hi, lo);
        check_val("done_after", 64'(done), 64'(0));
        check_val("hi", 64'(hi), 64'(hi_m));
        check_val("lo", 64'(lo), 64'(lo_m));
    endtask

    // MTHI/MTLO in IDLE.
    task automatic mt_write(input logic hw, input logic lw, input logic [31:0] val,
                            input logic dw, input logic fl);
        @(posedge clk); #1;
        start = 1'b0; hi_we = hw; lo_we = lw; a = val; dis_wr = dw; flush = fl;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0; dis_wr = 1'b0; flush = 1'b0;
        if (!dw && !fl) begin
            if (hw) hi_m = val;
            if (lw) lo_m = val;
        end
        @(negedge clk);
        $display("mt hi_we=%0b lo_we=%0b a=%h dis_wr=%0b flush=%0b -> hi=%h lo=%h",
                 hw, lw, val, dw, fl, hi, lo);
        check_val("mt_hi", 64'(hi), 64'(hi_m));
        check_val("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    // Start an op and flush it in cycle fc (cycle 0 = start cycle).
    task automatic flush_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input int fc, input logic ack_fl);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; ack = 1'b0; dis_wr = 1'b0; flush = 1'b0;
        for (int c = 1; c <= fc; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == fc) begin flush = 1'b1; ack = ack_fl; end
        end
        @(posedge clk); #1;
        flush = 1'b0; ack = 1'b0;
        @(negedge clk);
        $display("flush op=%0d at cycle %0d ack=%0b -> stall=%0b done=%0b hi=%h lo=%h",
                 o, fc, ack_fl, stall, done, hi, lo);
        check_val("flush_stall", 64'(stall), 64'(0));
        check_val("flush_done", 64'(done), 64'(0));
        check_val("flush_hi", 64'(hi), 64'(hi_m));
        check_val("flush_lo", 64'(lo), 64'(lo_m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; start = 1'b0; ack = 1'b0; dis_wr = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_val("rst_stall", 64'(stall), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_mul_lo", 64'(mul_lo), 64'(0));
        check_val("rst_hi", 64'(hi), 64'(0));
        check_val("rst_lo", 64'(lo), 64'(0));

        // MULT -2 * 3
        run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        check_val("plan_mult_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check_val("plan_mult_lo", 64'(lo), 64'(32'hFFFF_FFFA));
        // DIV -7 / 2
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check_val("plan_div_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check_val("plan_div_lo", 64'(lo), 64'(32'hFFFF_FFFD));
        // Divide by zero and signed overflow
        run_op(4'd3, 32'd5, 32'd0, 0, 1'b0);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        // Accumulate across the 64-bit boundary
        mt_write(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        mt_write(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(4'd5, 32'd1, 32'd1, 0, 1'b0);
        run_op(4'd6, 32'd1, 32'd1, 0, 1'b0);
        // Flushes: mid-divide, and in DONE together with ack
        flush_op(4'd2, 32'd1000, 32'd7, 10, 1'b0);
        flush_op(4'd0, 32'd12345, 32'd678, MS + 1, 1'b1);
        // Commit suppressed, held ack, MUL result path
        run_op(4'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1'b1);
        run_op(4'd0, 32'd77, 32'hFFFF_FF00, 3, 1'b0);
        run_op(4'd8, 32'h0001_0003, 32'h0002_0005, 2, 1'b0);
        // MTLO, then suppressed MTHI by dis_wr and by flush
        mt_write(1'b0, 1'b1, 32'h1234, 1'b0, 1'b0);
        mt_write(1'b1, 1'b0, 32'hAAAA_5555, 1'b1, 1'b0);
        mt_write(1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1);

        // Unused op code: no stall, never done
        @(posedge clk); #1;
        start = 1'b1; op = 4'd11; a = $urandom; b = $urandom;
        @(negedge clk);
        check_val("badop_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_val("badop_done", 64'(done), 64'(0));
        check_val("badop_stall2", 64'(stall), 64'(0));

        // Randomized mix of ops and MTHI/MTLO
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                         1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            else
                run_op(4'($urandom_range(0, 8)), rnd_operand(), rnd_operand(),
                       $urandom_range(0, 2), 1'($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        start = 1'b1; op = 4'd0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        check_val("midrst_stall", 64'(stall), 64'(0));
        check_val("midrst_done", 64'(done), 64'(0));
        check_val("midrst_mul_lo", 64'(mul_lo), 64'(0));
        check_val("midrst_hi", 64'(hi), 64'(hi_m));
        check_val("midrst_lo", 64'(lo), 64'(lo_m));
        run_op(4'd4, 32'd3, 32'hFFFF_FFFD, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
